// File: rtl/seg7_capture_decoder.sv
// Debounced capture of an active-low 7-segment bus, decoded back to a hex digit.
// Illegal stable patterns pulse pat_err and bump a saturating error counter.
module seg7_capture_decoder #(
    parameter int STABLE_CYCLES = 4
) (
    input  logic       CLOCK_50,
    input  logic       reset,
    input  logic [6:0] seg_in,
    input  logic       clr_err,
    output logic [3:0] digit,
    output logic       digit_valid,
    output logic       pat_err,
    output logic       blank,
    output logic [3:0] err_count
);

    localparam int CW = (STABLE_CYCLES < 2) ? 1 : $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0] CNT_ONE  = CW'(1);

    typedef enum logic {
        HOLD,
        COUNT
    } state_t;

    state_t      r_state;
    logic [6:0]  r_s1;
    logic [6:0]  r_s2;
    logic [6:0]  r_cand;
    logic [6:0]  r_last;
    logic [CW-1:0] r_cnt;
    logic [3:0]  r_digit;
    logic        r_dv;
    logic        r_pe;
    logic        r_blank;
    logic [3:0]  r_errc;

    logic [6:0]  w_p;
    logic [3:0]  w_dec;
    logic        w_legal;
    logic        w_blank;
    logic [3:0]  w_errc_inc;

    // Decode the candidate in active-high form
    always_comb begin
        w_p     = ~r_cand;
        w_dec   = 4'h0;
        w_legal = 1'b1;
        case (w_p)
            7'h7E: w_dec = 4'h0;
            7'h30: w_dec = 4'h1;
            7'h6D: w_dec = 4'h2;
            7'h79: w_dec = 4'h3;
            7'h33: w_dec = 4'h4;
            7'h5B: w_dec = 4'h5;
            7'h5F: w_dec = 4'h6;
            7'h70: w_dec = 4'h7;
            7'h7F: w_dec = 4'h8;
            7'h7B: w_dec = 4'h9;
            7'h77: w_dec = 4'hA;
            7'h1F: w_dec = 4'hB;
            7'h4E: w_dec = 4'hC;
            7'h3D: w_dec = 4'hD;
            7'h4F: w_dec = 4'hE;
            7'h47: w_dec = 4'hF;
            default: w_legal = 1'b0;
        endcase
        w_blank = (w_p == 7'h00);
    end

    assign w_errc_inc = (r_errc == 4'hF) ? 4'hF : r_errc + 4'd1;

    always_ff @(posedge CLOCK_50 or posedge reset) begin
        if (reset) begin
            r_state <= HOLD;
            r_s1    <= 7'h7F;
            r_s2    <= 7'h7F;
            r_cand  <= 7'h7F;
            r_last  <= 7'h7F;
            r_cnt   <= '0;
            r_digit <= 4'h0;
            r_dv    <= 1'b0;
            r_pe    <= 1'b0;
            r_blank <= 1'b1;
            r_errc  <= 4'h0;
        end else begin
            r_s1 <= seg_in;
            r_s2 <= r_s1;
            r_dv <= 1'b0;
            r_pe <= 1'b0;
            if (clr_err)
                r_errc <= 4'h0;
            case (r_state)
                HOLD: begin
                    if (r_s2 != r_cand) begin
                        r_cand  <= r_s2;
                        r_cnt   <= CNT_ONE;
                        r_state <= COUNT;
                    end
                end
                COUNT: begin
                    if (r_s2 != r_cand) begin
                        r_cand <= r_s2;
                        r_cnt  <= CNT_ONE;
                    end else if (r_cnt == CNT_LAST) begin
                        r_state <= HOLD;
                        // A glitch that settles back on the old pattern is ignored
                        if (r_cand != r_last) begin
                            r_last <= r_cand;
                            if (w_legal) begin
                                r_digit <= w_dec;
                                r_dv    <= 1'b1;
                                r_blank <= 1'b0;
                            end else if (w_blank) begin
                                r_blank <= 1'b1;
                            end else begin
                                r_pe    <= 1'b1;
                                r_blank <= 1'b0;
                                r_errc  <= clr_err ? 4'd1 : w_errc_inc;
                            end
                        end
                    end else begin
                        r_cnt <= r_cnt + CNT_ONE;
                    end
                end
                default: r_state <= HOLD;
            endcase
        end
    end

    assign digit       = r_digit;
    assign digit_valid = r_dv;
    assign pat_err     = r_pe;
    assign blank       = r_blank;
    assign err_count   = r_errc;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Directed bench for seg7_capture_decoder with a pulse scoreboard.
// A second instance runs with STABLE_CYCLES=2 for the latency check.
module tb_seg7_capture_decoder;

    localparam int STB = 4;

    typedef struct {
        logic       err;
        logic [3:0] dig;
        logic [3:0] ec;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [6:0] seg_in;
    logic [6:0] seg2;
    logic       clr;
    logic [3:0] digit, digit2;
    logic       dv, dv2, pe, pe2, blank, blank2;
    logic [3:0] ec, ec2;

    int checks = 0;
    int errors = 0;
    int dv_cnt = 0;
    int pe_cnt = 0;

    exp_t sb[$];
    exp_t m_e;
    logic [6:0] m_last  = 7'h00;
    logic [3:0] m_digit = 4'h0;
    logic [3:0] m_err   = 4'h0;

    logic [6:0] lut [16] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                             7'h7F, 7'h7B, 7'h77, 7'h1F, 7'h4E, 7'h3D, 7'h4F, 7'h47};

    seg7_capture_decoder #(.STABLE_CYCLES(STB)) dut (
        .CLOCK_50(clk), .reset(rst), .seg_in(seg_in), .clr_err(clr),
        .digit(digit), .digit_valid(dv), .pat_err(pe),
        .blank(blank), .err_count(ec)
    );

    seg7_capture_decoder #(.STABLE_CYCLES(2)) dut2 (
        .CLOCK_50(clk), .reset(rst), .seg_in(seg2), .clr_err(1'b0),
        .digit(digit2), .digit_valid(dv2), .pat_err(pe2),
        .blank(blank2), .err_count(ec2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Pulses are checked against the scoreboard on the falling edge
    always @(negedge clk) begin
        if (dv === 1'b1 || pe === 1'b1) begin
            if (dv === 1'b1) dv_cnt++;
            if (pe === 1'b1) pe_cnt++;
            chk("pulse_exclusive", {31'd0, dv & pe}, 32'd0);
            chk("unexpected_pulse", {31'd0, sb.size() > 0}, 32'd1);
            if (sb.size() > 0) begin
                m_e = sb.pop_front();
                chk("pulse_kind", {31'd0, pe}, {31'd0, m_e.err});
                chk("pulse_digit", {28'd0, digit}, {28'd0, m_e.dig});
                chk("pulse_errc", {28'd0, ec}, {28'd0, m_e.ec});
            end
        end
    end

    // p is active-high; stable holds (>= STB+2 cycles) of a new pattern commit
    task automatic hold(input logic [6:0] p, input int n);
        exp_t e;
        bit   found;
        if (n >= STB + 2 && p != m_last) begin
            m_last = p;
            found  = 1'b0;
            for (int i = 0; i < 16; i++)
                if (lut[i] == p && !found) begin
                    found   = 1'b1;
                    m_digit = 4'(i);
                end
            if (found) begin
                e.err = 1'b0; e.dig = m_digit; e.ec = m_err;
                sb.push_back(e);
            end else if (p != 7'h00) begin
                m_err = (m_err == 4'hF) ? 4'hF : m_err + 4'd1;
                e.err = 1'b1; e.dig = m_digit; e.ec = m_err;
                sb.push_back(e);
            end
        end
        seg_in = ~p;
        repeat (n) @(negedge clk);
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, "_digit"}, {28'd0, digit}, 32'd0);
        chk({tag, "_dv"}, {31'd0, dv}, 32'd0);
        chk({tag, "_pe"}, {31'd0, pe}, 32'd0);
        chk({tag, "_blank"}, {31'd0, blank}, 32'd1);
        chk({tag, "_errc"}, {28'd0, ec}, 32'd0);
    endtask

    initial begin
        exp_t e;
        int   d0, p0;
        rst = 1'b1; seg_in = 7'h7F; seg2 = 7'h7F; clr = 1'b0;
        repeat (3) @(negedge clk);
        chk_reset_vals("reset");

        // first commit lands exactly on edge 5 after release
        seg_in = ~7'h30;
        m_last = 7'h30; m_digit = 4'h1;
        e.err = 1'b0; e.dig = 4'h1; e.ec = 4'h0;
        sb.push_back(e);
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 8; i++) begin
            @(posedge clk); #1;
            chk("t1_edge_dv", {31'd0, dv}, {31'd0, i == 5});
        end
        chk("t1_digit", {28'd0, digit}, 32'd1);
        chk("t1_blank", {31'd0, blank}, 32'd0);
        @(negedge clk);

        // all sixteen legal digits
        d0 = dv_cnt; p0 = pe_cnt;
        for (int i = 0; i < 16; i++) hold(lut[i], 10);
        chk("t2_dv_count", dv_cnt - d0, 16);
        chk("t2_pe_count", pe_cnt - p0, 0);
        chk("t2_digit", {28'd0, digit}, 32'hF);

        // glitches back to the held pattern are ignored
        hold(7'h5B, 10);
        d0 = dv_cnt;
        hold(7'h7E, 3);
        hold(7'h5B, 10);
        chk("t3_no_dv", dv_cnt - d0, 0);
        chk("t3_digit", {28'd0, digit}, 32'h5);
        p0 = pe_cnt;
        hold(7'h01, 3);
        hold(7'h5B, 10);
        chk("t3_no_pe", pe_cnt - p0, 0);
        chk("t3_errc", {28'd0, ec}, 32'd0);

        // illegal patterns and saturation
        hold(7'h01, 10);
        chk("t4_errc1", {28'd0, ec}, 32'd1);
        chk("t4_digit", {28'd0, digit}, 32'h5);
        chk("t4_blank", {31'd0, blank}, 32'd0);
        for (int k = 0; k < 17; k++) hold((k % 2) ? 7'h01 : 7'h02, 10);
        chk("t4_errc_sat", {28'd0, ec}, 32'd15);

        // clr_err coinciding with an illegal commit
        m_last = 7'h01; m_err = 4'd1;
        e.err = 1'b1; e.dig = m_digit; e.ec = 4'd1;
        sb.push_back(e);
        seg_in = ~7'h01;
        repeat (5) @(negedge clk);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        repeat (4) @(negedge clk);
        chk("t4_clr_commit", {28'd0, ec}, 32'd1);
        clr = 1'b1;
        @(negedge clk);
        clr = 1'b0;
        m_err = 4'd0;
        chk("t4_clr_alone", {28'd0, ec}, 32'd0);

        // blank in the middle of a legal sequence
        hold(7'h77, 10);
        d0 = dv_cnt;
        hold(7'h00, 10);
        chk("t5_blank", {31'd0, blank}, 32'd1);
        chk("t5_digit", {28'd0, digit}, 32'hA);
        chk("t5_no_dv", dv_cnt - d0, 0);
        hold(7'h77, 10);
        chk("t5_dv_again", dv_cnt - d0, 1);
        chk("t5_unblank", {31'd0, blank}, 32'd0);

        // reset asserted while counting
        seg_in = ~7'h30;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        #1;
        chk_reset_vals("t6_midcount");
        seg_in = 7'h7F;
        m_last = 7'h00; m_err = 4'h0; m_digit = 4'h0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        d0 = dv_cnt; p0 = pe_cnt;
        hold(7'h00, 12);
        chk("t6_static_off_dv", dv_cnt - d0, 0);
        chk("t6_static_off_pe", pe_cnt - p0, 0);
        chk("t6_blank", {31'd0, blank}, 32'd1);

        // STABLE_CYCLES=2 commits on edge 3
        rst = 1'b1;
        seg2 = ~7'h79;
        @(negedge clk);
        rst = 1'b0;
        for (int i = 0; i < 6; i++) begin
            @(posedge clk); #1;
            chk("t6_s2_edge_dv", {31'd0, dv2}, {31'd0, i == 3});
        end
        chk("t6_s2_digit", {28'd0, digit2}, 32'd3);
        chk("t6_s2_pe", {31'd0, pe2}, 32'd0);

        @(negedge clk);
        chk("sb_drained", sb.size(), 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
